// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit-side control blocks.
package uart_ctrl_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_ACK,
    ST_DONE
  } state_t;

  // Ceiling log2 usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    j          = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && (|(req & (N'(1) << j)))) begin
        found      = 1'b1;
        gnt_idx    = IDW'(j);
        gnt_onehot = N'(1) << j;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for a shared uart_tx: accepts one byte, pulses start,
// then follows busy until the frame completes; flags a missing busy acknowledge.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDW         = clog2(NUM_REQ),
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [IDW-1:0]                 grant_id,
  output logic                           active,
  output logic                           err_no_ack,
  input  logic                           err_clr
);

  localparam int unsigned ACK_W = clog2(ACK_TIMEOUT) + 1;

  state_t                 state;
  logic [IDW-1:0]         rr_ptr;
  logic [ACK_W-1:0]       ack_cnt;
  logic [NUM_REQ-1:0]     gnt_onehot;
  logic [IDW-1:0]         gnt_idx;
  logic                   gnt_any;
  logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
  end

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // A stray busy frame in IDLE blocks acceptance entirely.
  assign req_ready = (state == ST_IDLE && !tx_busy) ? gnt_onehot : '0;
  assign active    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      err_no_ack <= 1'b0;
      ack_cnt    <= '0;
    end else begin
      tx_start <= 1'b0;
      // A timeout set below overrides a clear in the same cycle.
      if (err_clr) err_no_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!tx_busy && gnt_any) begin
            tx_data  <= req_bytes[gnt_idx];
            grant_id <= gnt_idx;
            rr_ptr   <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
            tx_start <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          ack_cnt <= '0;
          state   <= ST_ACK;
        end
        ST_ACK: begin
          ack_cnt <= ack_cnt + ACK_W'(1);
          if (tx_busy) begin
            state <= ST_DONE;
          end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            err_no_ack <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!tx_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and serial-line decoder.
module tb_uart_tx_arbiter;

  localparam int CPB = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_no_ack;
  logic        err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mode = 0;        // 0 real uart model, 1 stub busy=0, 2 busy forced 1
  int onehot_bad = 0;

  logic       m_busy = 1'b0;
  logic       line = 1'b1;
  logic [9:0] sh = '0;
  int         m_cnt = 0;
  int         m_bit = 0;

  logic       nxt_v [4] = '{default: 1'b0};
  logic [7:0] nxt_d [4] = '{default: 8'h00};
  logic [3:0] hs;
  logic       prev_busy = 1'b0;

  logic [7:0] rx_q[$];
  logic [1:0] gnt_q[$];
  int         start_q[$];
  int         fall_q[$];

  uart_tx_arbiter #(.NUM_REQ(4), .IDW(2), .ACK_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .err_no_ack (err_no_ack),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : m_busy;

  // uart_tx model: 1 start, 8 data LSB first, 1 stop, busy for 10*CPB cycles
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; line <= 1'b1; m_cnt <= 0; m_bit <= 0;
    end else if (!m_busy) begin
      if (tx_start && mode == 0) begin
        sh <= {1'b1, tx_data, 1'b0}; m_busy <= 1'b1; line <= 1'b0; m_cnt <= 0; m_bit <= 0;
      end
    end else if (m_cnt == CPB - 1) begin
      m_cnt <= 0;
      if (m_bit == 9) begin
        m_busy <= 1'b0; line <= 1'b1;
      end else begin
        m_bit <= m_bit + 1; line <= sh[m_bit+1];
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Serial decoder sampling mid-bit
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge line);
      repeat (CPB / 2) @(posedge clk);
      if (!line) begin
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(posedge clk);
          b[k] = line;
        end
        repeat (CPB) @(posedge clk);
        rx_q.push_back(b);
      end
    end
  end

  // Requester side: retire handshaken bytes just after the edge, load the queued next byte
  always @(posedge clk) begin
    hs = req_valid & req_ready;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        if (nxt_v[i]) begin
          req_data[8*i +: 8] = nxt_d[i];
          nxt_v[i] = 1'b0;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Event log and ready legality monitor
  always @(negedge clk) begin
    if (tx_start) begin
      gnt_q.push_back(grant_id);
      start_q.push_back(cyc);
    end
    if (prev_busy && !tx_busy) fall_q.push_back(cyc);
    prev_busy = tx_busy;
    if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 4'b0) onehot_bad++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    if (!req_valid[i]) begin
      req_data[8*i +: 8] = b;
      req_valid[i] = 1'b1;
    end else begin
      nxt_d[i] = b;
      nxt_v[i] = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (!active && !tx_busy && req_valid == 4'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_vec++; if (err_no_ack !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_no_ack); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    rx_q.delete(); fall_q.delete();
    push(2, 8'hA5);
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    step();
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", tx_start); end
    n_vec++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
    step();
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", tx_start); end
    wait_rx(1, ok);
    n_vec++; if (!ok || rx_q[0] !== 8'hA5) begin n_err++; $display("FAIL single_line: got %h want a5 (ok=%0d)", ok ? rx_q[0] : 8'hxx, ok); end
    for (int k = 0; k < 20000 && active; k++) step();
    n_vec++; if (active !== 1'b0 || fall_q.size() == 0 || cyc - fall_q[$] != 1) begin
      n_err++; $display("FAIL single_active_drop: active=%b cycles_after_busy_fall=%0d want 0/1", active, fall_q.size() ? cyc - fall_q[$] : -1);
    end
  endtask

  task automatic test_all_four();
    bit ok;
    rst = 1'b1; step(); rst = 1'b0;
    rx_q.delete(); gnt_q.delete();
    for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i));
    wait_rx(4, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL all4_count: got %0d bytes want 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (rx_q[i] !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL all4_byte%0d: got %h want %h", i, rx_q[i], 8'h10 + 8'(i)); end
      n_vec++; if (gnt_q[i] !== 2'(i)) begin n_err++; $display("FAIL all4_grant%0d: got %0d want %0d", i, gnt_q[i], i); end
    end
    wait_idle(ok);
    push(0, 8'h20);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ready: got %b want 0001", req_ready); end
    wait_rx(5, ok);
    n_vec++; if (rx_q[4] !== 8'h20 || gnt_q[4] !== 2'd0) begin n_err++; $display("FAIL wrap_grant: got byte %h id %0d want 20 id 0", rx_q[4], gnt_q[4]); end
    wait_idle(ok);
    push(0, 8'h30); push(1, 8'h31);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rr_ptr1_ready: got %b want 0010", req_ready); end
    wait_rx(7, ok);
    n_vec++; if (rx_q[5] !== 8'h31 || rx_q[6] !== 8'h30) begin n_err++; $display("FAIL rr_ptr1_order: got %h,%h want 31,30", rx_q[5], rx_q[6]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_idle(ok);
    rx_q.delete(); start_q.delete(); fall_q.delete();
    push(1, 8'h55); push(1, 8'hAA);
    wait_rx(2, ok);
    n_vec++; if (!ok || rx_q[0] !== 8'h55 || rx_q[1] !== 8'hAA) begin n_err++; $display("FAIL b2b_bytes: got %h,%h want 55,aa", rx_q[0], rx_q[1]); end
    n_vec++; if (start_q.size() < 2 || fall_q.size() < 1 || start_q[1] - fall_q[0] != 2) begin
      n_err++; $display("FAIL b2b_gap: got %0d cycles want 2", (start_q.size() >= 2 && fall_q.size() >= 1) ? start_q[1] - fall_q[0] : -1);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int early;
    wait_idle(ok);
    mode = 1;
    early = 0;
    push(0, 8'h3C);
    wait_start(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL to_start: got no tx_start want one"); end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (err_no_ack !== 1'b0 || active !== 1'b1) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL to_early: got %0d bad cycles want 0", early); end
    step();
    n_vec++; if (err_no_ack !== 1'b1) begin n_err++; $display("FAIL to_err_set: got %b want 1", err_no_ack); end
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL to_idle: got active %b want 0", active); end
    step(); step(); step();
    n_vec++; if (err_no_ack !== 1'b1 || active !== 1'b0) begin n_err++; $display("FAIL to_sticky: got err %b active %b want 1 0", err_no_ack, active); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_vec++; if (err_no_ack !== 1'b0) begin n_err++; $display("FAIL to_clr: got %b want 0", err_no_ack); end
    push(1, 8'h3D);
    wait_start(ok);
    repeat (8) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_vec++; if (err_no_ack !== 1'b1) begin n_err++; $display("FAIL to_set_wins: got %b want 1", err_no_ack); end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_idle(ok);
    push(3, 8'h77);
    wait_start(ok);
    repeat (300) step();
    rst = 1'b1; step();
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL rmid_tx_start: got %b want 0", tx_start); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rmid_tx_data: got %h want 00", tx_data); end
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rmid_req_ready: got %b want 0000", req_ready); end
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL rmid_active: got %b want 0", active); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rmid_grant_id: got %0d want 0", grant_id); end
    n_vec++; if (err_no_ack !== 1'b0) begin n_err++; $display("FAIL rmid_err: got %b want 0", err_no_ack); end
    rst = 1'b0;
    repeat (11 * CPB) step();
    rx_q.delete(); gnt_q.delete();
    push(1, 8'hC3);
    wait_rx(1, ok);
    n_vec++; if (!ok || rx_q[0] !== 8'hC3 || gnt_q[0] !== 2'd1) begin n_err++; $display("FAIL rmid_after: got %h id %0d want c3 id 1", rx_q[0], gnt_q[0]); end
  endtask

  task automatic test_busy_hold();
    bit ok;
    wait_idle(ok);
    rx_q.delete();
    mode = 2;
    push(0, 8'h5A);
    #1;
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (req_ready !== 4'b0 || active !== 1'b0) begin n_err++; $display("FAIL hold_ready%0d: got ready %b active %b want 0000 0", k, req_ready, active); end
      step();
    end
    mode = 0;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL hold_release: got %b want 0001", req_ready); end
    step();
    n_vec++; if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin n_err++; $display("FAIL hold_start: got start %b data %h want 1 5a", tx_start, tx_data); end
    wait_rx(1, ok);
    n_vec++; if (!ok || rx_q[0] !== 8'h5A) begin n_err++; $display("FAIL hold_line: got %h want 5a", rx_q[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_busy_hold();
    n_vec++; if (onehot_bad != 0) begin n_err++; $display("FAIL ready_onehot: got %0d illegal cycles want 0", onehot_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
